// File: rtl/y86_ppl_ctrl.sv
// y86_ppl_ctrl: pipeline stall/bubble control, debug run sequencer,
// final status latch and saturating performance counters for the 5-stage Y86 core.
module y86_ppl_ctrl #(
    parameter  int unsigned CNT_W  = 32,
    localparam int unsigned CODE_W = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_run_en,
    input  logic              i_step,
    input  logic [CODE_W-1:0] i_d_icode,
    input  logic [CODE_W-1:0] i_d_srca,
    input  logic [CODE_W-1:0] i_d_srcb,
    input  logic [CODE_W-1:0] i_e_icode,
    input  logic [CODE_W-1:0] i_e_dstm,
    input  logic              i_e_cnd,
    input  logic [CODE_W-1:0] i_m_icode,
    input  logic [CODE_W-1:0] i_m_stat,
    input  logic [CODE_W-1:0] i_w_icode,
    input  logic [CODE_W-1:0] i_w_stat,
    output logic              o_f_stall_c,
    output logic              o_d_stall_c,
    output logic              o_d_bubble_c,
    output logic              o_e_bubble_c,
    output logic              o_m_bubble_c,
    output logic              o_w_stall_c,
    output logic              o_w_bubble_c,
    output logic              o_set_cc_c,
    output logic              o_halted,
    output logic [CODE_W-1:0] o_cpu_stat,
    output logic [CNT_W-1:0]  o_cycle_cnt,
    output logic [CNT_W-1:0]  o_instr_cnt,
    output logic [CNT_W-1:0]  o_bubble_cnt
);

    localparam logic [CODE_W-1:0] I_NOP    = 4'h1;
    localparam logic [CODE_W-1:0] I_MRMOVL = 4'h5;
    localparam logic [CODE_W-1:0] I_OPL    = 4'h6;
    localparam logic [CODE_W-1:0] I_JXX    = 4'h7;
    localparam logic [CODE_W-1:0] I_RET    = 4'h9;
    localparam logic [CODE_W-1:0] I_POPL   = 4'hB;
    localparam logic [CODE_W-1:0] S_OK     = 4'h1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_STEP  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_lu;
    logic              w_ret;
    logic              w_mp;
    logic              w_exc_m;
    logic              w_exc_w;
    logic              w_active;
    logic              w_enter_stop;
    logic              r_halted;
    logic [CODE_W-1:0] r_cpu_stat;
    logic [CNT_W-1:0]  r_cycle_cnt;
    logic [CNT_W-1:0]  r_instr_cnt;
    logic [CNT_W-1:0]  r_bubble_cnt;

    // Hazard terms from current stage registers
    assign w_lu    = ((i_e_icode == I_MRMOVL) || (i_e_icode == I_POPL)) &&
                     ((i_e_dstm == i_d_srca) || (i_e_dstm == i_d_srcb));
    assign w_ret   = (i_d_icode == I_RET) || (i_e_icode == I_RET) || (i_m_icode == I_RET);
    assign w_mp    = (i_e_icode == I_JXX) && !i_e_cnd;
    assign w_exc_m = (i_m_stat != S_OK);
    assign w_exc_w = (i_w_stat != S_OK);

    assign w_active     = (r_state == ST_RUN) || (r_state == ST_STEP);
    assign w_enter_stop = (w_state_nxt == ST_STOP) && (r_state != ST_STOP);

    // Sequencer state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencer next state; a W-stage exception wins over run_en/step
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_exc_w)        w_state_nxt = ST_STOP;
                else if (!i_run_en) w_state_nxt = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (i_run_en)       w_state_nxt = ST_RUN;
                else if (i_step)    w_state_nxt = ST_STEP;
            end
            ST_STEP: begin
                if (w_exc_w)        w_state_nxt = ST_STOP;
                else                w_state_nxt = i_run_en ? ST_RUN : ST_PAUSE;
            end
            ST_STOP:                w_state_nxt = ST_STOP;
            default:                w_state_nxt = ST_RUN;
        endcase
    end

    // Pipeline controls: frozen pattern by default, hazard equations when active
    always_comb begin
        o_f_stall_c  = 1'b1;
        o_d_stall_c  = 1'b1;
        o_d_bubble_c = 1'b0;
        o_e_bubble_c = 1'b0;
        o_m_bubble_c = 1'b0;
        o_w_stall_c  = 1'b1;
        o_set_cc_c   = 1'b0;
        if (w_active) begin
            o_f_stall_c  = w_lu || w_ret;
            o_d_stall_c  = w_lu;
            o_d_bubble_c = w_mp || (w_ret && !w_lu);
            o_e_bubble_c = w_mp || w_lu;
            o_m_bubble_c = w_exc_m || w_exc_w;
            o_w_stall_c  = w_exc_w;
            o_set_cc_c   = (i_e_icode == I_OPL) && !w_exc_m && !w_exc_w;
        end
    end

    assign o_w_bubble_c = 1'b0;

    // Final status latch and saturating counters
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_halted     <= 1'b0;
            r_cpu_stat   <= S_OK;
            r_cycle_cnt  <= '0;
            r_instr_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_enter_stop) begin
                r_halted   <= 1'b1;
                r_cpu_stat <= i_w_stat;
            end
            if (w_active) begin
                if (r_cycle_cnt != CNT_MAX) begin
                    r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
                end
                if (!w_exc_w && (i_w_icode != I_NOP) && (r_instr_cnt != CNT_MAX)) begin
                    r_instr_cnt <= r_instr_cnt + CNT_W'(1);
                end
                if ((o_d_bubble_c || o_e_bubble_c) && (r_bubble_cnt != CNT_MAX)) begin
                    r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_halted     = r_halted;
    assign o_cpu_stat   = r_cpu_stat;
    assign o_cycle_cnt  = r_cycle_cnt;
    assign o_instr_cnt  = r_instr_cnt;
    assign o_bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_y86_ppl_ctrl.sv
// tb_y86_ppl_ctrl: directed and randomized checks of the Y86 pipeline control unit
// against a cycle-level behavioural model (active/stopped flags plus counters).
module tb_y86_ppl_ctrl;

    localparam logic [3:0] I_HALT = 4'h0, I_NOP = 4'h1, I_MRMOVL = 4'h5, I_OPL = 4'h6;
    localparam logic [3:0] I_JXX = 4'h7, I_RET = 4'h9, I_POPL = 4'hB;
    localparam logic [3:0] S_OK = 4'h1, S_HLT = 4'h2, S_ADR = 4'h3, S_INS = 4'h4;
    localparam logic [3:0] R_NONE = 4'hF;
    localparam logic [7:0] FROZEN = 8'b1100_0100;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic run_en, step, e_cnd;
    logic [3:0] d_icode, d_srca, d_srcb, e_icode, e_dstm, m_icode, m_stat, w_icode, w_stat;

    logic f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, w_bubble, set_cc, halted;
    logic [3:0] cpu_stat;
    logic [31:0] cyc, ins, bub;
    logic s_f_stall, s_d_stall, s_d_bubble, s_e_bubble, s_m_bubble, s_w_stall, s_w_bubble, s_set_cc;
    logic s_halted;
    logic [3:0] s_cpu_stat, cyc4, ins4, bub4;
    logic [7:0] got_comb, got_comb4;

    int total = 0;
    int bad = 0;

    // behavioural model: does the next cycle advance the pipe, has the core stopped
    bit m_active, m_stopped;
    logic [3:0] m_cpu;
    longint unsigned m_cyc, m_ins, m_bub;

    always #5 clk = ~clk;

    assign got_comb  = {f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, w_bubble, set_cc};
    assign got_comb4 = {s_f_stall, s_d_stall, s_d_bubble, s_e_bubble, s_m_bubble, s_w_stall,
                        s_w_bubble, s_set_cc};

    y86_ppl_ctrl u_dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_run_en(run_en), .i_step(step),
        .i_d_icode(d_icode), .i_d_srca(d_srca), .i_d_srcb(d_srcb),
        .i_e_icode(e_icode), .i_e_dstm(e_dstm), .i_e_cnd(e_cnd),
        .i_m_icode(m_icode), .i_m_stat(m_stat), .i_w_icode(w_icode), .i_w_stat(w_stat),
        .o_f_stall_c(f_stall), .o_d_stall_c(d_stall), .o_d_bubble_c(d_bubble),
        .o_e_bubble_c(e_bubble), .o_m_bubble_c(m_bubble), .o_w_stall_c(w_stall),
        .o_w_bubble_c(w_bubble), .o_set_cc_c(set_cc), .o_halted(halted),
        .o_cpu_stat(cpu_stat), .o_cycle_cnt(cyc), .o_instr_cnt(ins), .o_bubble_cnt(bub)
    );

    y86_ppl_ctrl #(.CNT_W(4)) u_dut4 (
        .i_clk(clk), .i_reset_n(rst_n), .i_run_en(run_en), .i_step(step),
        .i_d_icode(d_icode), .i_d_srca(d_srca), .i_d_srcb(d_srcb),
        .i_e_icode(e_icode), .i_e_dstm(e_dstm), .i_e_cnd(e_cnd),
        .i_m_icode(m_icode), .i_m_stat(m_stat), .i_w_icode(w_icode), .i_w_stat(w_stat),
        .o_f_stall_c(s_f_stall), .o_d_stall_c(s_d_stall), .o_d_bubble_c(s_d_bubble),
        .o_e_bubble_c(s_e_bubble), .o_m_bubble_c(s_m_bubble), .o_w_stall_c(s_w_stall),
        .o_w_bubble_c(s_w_bubble), .o_set_cc_c(s_set_cc), .o_halted(s_halted),
        .o_cpu_stat(s_cpu_stat), .o_cycle_cnt(cyc4), .o_instr_cnt(ins4), .o_bubble_cnt(bub4)
    );

    // expected controls, bit order {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,W_bubble,set_cc}
    function automatic logic [7:0] exp_comb();
        bit lu, ret, mp, xm, xw;
        lu  = ((e_icode == I_MRMOVL) || (e_icode == I_POPL)) && ((e_dstm == d_srca) || (e_dstm == d_srcb));
        ret = (d_icode == I_RET) || (e_icode == I_RET) || (m_icode == I_RET);
        mp  = (e_icode == I_JXX) && !e_cnd;
        xm  = (m_stat != S_OK);
        xw  = (w_stat != S_OK);
        if (!m_active) return FROZEN;
        return {lu | ret, lu, mp | (ret & !lu), mp | lu, xm | xw, xw, 1'b0,
                (e_icode == I_OPL) && !xm && !xw};
    endfunction

    function automatic longint unsigned sat4(longint unsigned v);
        return (v > 15) ? 64'd15 : v;
    endfunction

    function automatic void model_reset();
        m_active = 1'b1; m_stopped = 1'b0; m_cpu = S_OK;
        m_cyc = 0; m_ins = 0; m_bub = 0;
    endfunction

    // advance the model across one rising edge using the currently driven inputs
    function automatic void model_update();
        logic [7:0] c;
        bit xw;
        c  = exp_comb();
        xw = (w_stat != S_OK);
        if (m_active) begin
            m_cyc++;
            if (!xw && (w_icode != I_NOP)) m_ins++;
            if (c[5] || c[4]) m_bub++;
            if (xw) begin
                m_stopped = 1'b1; m_active = 1'b0; m_cpu = w_stat;
            end else begin
                m_active = run_en;
            end
        end else if (!m_stopped) begin
            m_active = run_en | step;
        end
    endfunction

    task automatic set_nop();
        run_en = 1'b1; step = 1'b0; e_cnd = 1'b1;
        d_icode = I_NOP; e_icode = I_NOP; m_icode = I_NOP; w_icode = I_NOP;
        d_srca = R_NONE; d_srcb = R_NONE; e_dstm = R_NONE;
        m_stat = S_OK; w_stat = S_OK;
    endtask

    task automatic clk_step();
        model_update();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_nop();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if ({halted, cpu_stat} !== {1'b0, S_OK}) begin
            bad++; $display("FAIL reset_stat got=%b exp=%b", {halted, cpu_stat}, {1'b0, S_OK});
        end
        total++;
        if ({cyc, ins, bub, cyc4, ins4, bub4} !== 108'd0) begin
            bad++; $display("FAIL reset_cnt got=%h/%h/%h exp=0", cyc, ins, bub);
        end
        total++;
        if (got_comb !== 8'h00) begin
            bad++; $display("FAIL reset_comb got=%b exp=%b", got_comb, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        set_nop();
        e_icode = I_MRMOVL; e_dstm = 4'h0; d_icode = I_OPL; d_srca = 4'h0; d_srcb = 4'h3;
        #1;
        total++;
        if ({f_stall, d_stall, d_bubble, e_bubble} !== 4'b1101) begin
            bad++; $display("FAIL load_use got=%b exp=1101", {f_stall, d_stall, d_bubble, e_bubble});
        end
        clk_step();
        set_nop();
        #1;
        total++;
        if (bub !== 32'(m_bub)) begin
            bad++; $display("FAIL load_use_bubcnt got=%0d exp=%0d", bub, m_bub);
        end
        clk_step();
    endtask

    task automatic test_ret();
        for (int s = 0; s < 3; s++) begin
            set_nop();
            if (s == 0) d_icode = I_RET;
            if (s == 1) e_icode = I_RET;
            if (s == 2) m_icode = I_RET;
            #1;
            total++;
            if ({f_stall, d_stall, d_bubble, e_bubble} !== 4'b1010) begin
                bad++; $display("FAIL ret_stage%0d got=%b exp=1010", s, {f_stall, d_stall, d_bubble, e_bubble});
            end
            clk_step();
        end
        set_nop();
        d_icode = I_RET; e_icode = I_MRMOVL; e_dstm = 4'h2; d_srca = 4'h2;
        #1;
        total++;
        if ({f_stall, d_stall, d_bubble, e_bubble} !== 4'b1101) begin
            bad++; $display("FAIL ret_lu got=%b exp=1101", {f_stall, d_stall, d_bubble, e_bubble});
        end
        clk_step();
    endtask

    task automatic test_mispredict();
        set_nop();
        e_icode = I_JXX; e_cnd = 1'b0;
        #1;
        total++;
        if ({f_stall, d_bubble, e_bubble} !== 3'b011) begin
            bad++; $display("FAIL mispredict got=%b exp=011", {f_stall, d_bubble, e_bubble});
        end
        clk_step();
        e_cnd = 1'b1;
        #1;
        total++;
        if (got_comb !== 8'h00) begin
            bad++; $display("FAIL taken_jump got=%b exp=%b", got_comb, 8'h00);
        end
        clk_step();
    endtask

    task automatic test_pause_step();
        longint unsigned c0;
        set_nop();
        run_en = 1'b0;
        #1;
        clk_step();
        c0 = m_cyc;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if ({got_comb, cyc} !== {FROZEN, 32'(c0)}) begin
                bad++; $display("FAIL pause_frozen k=%0d got=%b/%0d exp=%b/%0d", k, got_comb, cyc, FROZEN, c0);
            end
            clk_step();
        end
        step = 1'b1;
        #1;
        clk_step();
        step = 1'b0; m_stat = S_ADR; e_icode = I_OPL;
        #1;
        total++;
        if (got_comb !== 8'b0000_1000) begin
            bad++; $display("FAIL step_adr got=%b exp=%b", got_comb, 8'b0000_1000);
        end
        clk_step();
        m_stat = S_OK; e_icode = I_NOP;
        #1;
        total++;
        if ({got_comb, cyc} !== {FROZEN, 32'(c0 + 1)}) begin
            bad++; $display("FAIL step_once got=%b/%0d exp=%b/%0d", got_comb, cyc, FROZEN, c0 + 1);
        end
        clk_step();
        run_en = 1'b1;
        #1;
        clk_step();
    endtask

    task automatic test_halt();
        longint unsigned c0;
        set_nop();
        w_stat = S_HLT; w_icode = I_HALT;
        #1;
        total++;
        if (got_comb !== 8'b0000_1100) begin
            bad++; $display("FAIL halt_cycle got=%b exp=%b", got_comb, 8'b0000_1100);
        end
        clk_step();
        c0 = m_cyc;
        for (int k = 0; k < 4; k++) begin
            set_nop();
            run_en = k[0]; step = !k[0];
            #1;
            total++;
            if ({halted, cpu_stat, got_comb} !== {1'b1, S_HLT, FROZEN}) begin
                bad++; $display("FAIL halt_stop k=%0d got=%b exp=%b", k, {halted, cpu_stat, got_comb}, {1'b1, S_HLT, FROZEN});
            end
            total++;
            if (cyc !== 32'(c0)) begin
                bad++; $display("FAIL halt_frozen_cnt got=%0d exp=%0d", cyc, c0);
            end
            clk_step();
        end
        apply_reset();
    endtask

    task automatic test_reset_mid_step();
        set_nop();
        run_en = 1'b0;
        #1;
        clk_step();
        step = 1'b1;
        #1;
        clk_step();
        step = 1'b0; e_icode = I_JXX; e_cnd = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if ({halted, cpu_stat, cyc, ins, bub} !== {1'b0, S_OK, 96'd0}) begin
            bad++; $display("FAIL rst_mid_step got=%b/%0d/%0d/%0d exp=0%b/0/0/0", {halted, cpu_stat}, cyc, ins, bub, S_OK);
        end
        total++;
        if (got_comb !== 8'b0011_0000) begin
            bad++; $display("FAIL rst_mid_step_comb got=%b exp=%b", got_comb, 8'b0011_0000);
        end
        @(negedge clk);
        run_en = 1'b1;
        rst_n = 1'b1;
    endtask

    task automatic test_saturate();
        logic [3:0] e4;
        apply_reset();
        set_nop();
        w_icode = I_OPL; e_icode = I_JXX; e_cnd = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (k == 14 || k == 15 || k == 16 || k == 19) begin
                e4 = (k >= 15) ? 4'hF : 4'(k);
                total++;
                if ({cyc4, ins4, bub4} !== {e4, e4, e4}) begin
                    bad++; $display("FAIL sat4 k=%0d got=%h exp=%h", k, {cyc4, ins4, bub4}, {e4, e4, e4});
                end
                total++;
                if (cyc !== 32'(k)) begin
                    bad++; $display("FAIL sat_wide k=%0d got=%0d exp=%0d", k, cyc, k);
                end
            end
            clk_step();
        end
    endtask

    task automatic test_random();
        logic [7:0] ec;
        for (int i = 0; i < 800; i++) begin
            d_icode = 4'($urandom_range(0, 11));
            e_icode = 4'($urandom_range(0, 11));
            m_icode = 4'($urandom_range(0, 11));
            w_icode = 4'($urandom_range(0, 11));
            d_srca  = 4'($urandom_range(0, 3));
            d_srcb  = 4'($urandom_range(0, 3));
            e_dstm  = 4'($urandom_range(0, 3));
            e_cnd   = 1'($urandom_range(0, 1));
            m_stat  = ($urandom_range(0, 7) == 0) ? S_ADR : S_OK;
            w_stat  = ($urandom_range(0, 59) == 0) ? S_INS : S_OK;
            run_en  = ($urandom_range(0, 5) != 0);
            step    = ($urandom_range(0, 2) == 0);
            #1;
            ec = exp_comb();
            total++;
            if (got_comb !== ec) begin
                bad++; $display("FAIL rnd_comb i=%0d got=%b exp=%b", i, got_comb, ec);
            end
            total++;
            if ({halted, cpu_stat} !== {m_stopped, m_cpu}) begin
                bad++; $display("FAIL rnd_stat i=%0d got=%b exp=%b", i, {halted, cpu_stat}, {m_stopped, m_cpu});
            end
            total++;
            if ({cyc, ins, bub} !== {32'(m_cyc), 32'(m_ins), 32'(m_bub)}) begin
                bad++; $display("FAIL rnd_cnt i=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, cyc, ins, bub, m_cyc, m_ins, m_bub);
            end
            total++;
            if ({got_comb4, s_halted, s_cpu_stat, cyc4, ins4, bub4} !==
                {ec, m_stopped, m_cpu, 4'(sat4(m_cyc)), 4'(sat4(m_ins)), 4'(sat4(m_bub))}) begin
                bad++; $display("FAIL rnd_small i=%0d got=%h/%h/%h exp=%0d/%0d/%0d", i, cyc4, ins4, bub4,
                                sat4(m_cyc), sat4(m_ins), sat4(m_bub));
            end
            if (m_stopped && ($urandom_range(0, 3) == 0)) apply_reset();
            else clk_step();
        end
    endtask

    initial begin
        set_nop();
        model_reset();
        test_reset();
        test_load_use();
        test_ret();
        test_mispredict();
        test_pause_step();
        test_halt();
        test_reset_mid_step();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
